gray_code_counter: RTL

- Parameterised up/down binary counter with a registered Gray-code output and a valid/ready output handshake.
- Sits directly upstream of the team's Gray-to-binary converter and drives its G input.
- Supplies the Gray sequences that the converter and its bench consume: step, load, wrap and stall.
- Single clock domain; all outputs registered.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/binary_to_gray_ds.sv | 13 +
 rtl/gray_code_counter.sv | 83 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the downstream converter bench.
package gray_pkg;

    localparam int unsigned GRAY_SIZE_DEFAULT = 4;
    localparam int unsigned GRAY_MAX_WIDTH    = 32;

    // Width-generic through zero extension; callers cast the result back to their width.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray_max_bin(input int unsigned size);
        logic [GRAY_MAX_WIDTH-1:0] one;
        one = 1;
        if (size >= GRAY_MAX_WIDTH) begin
            return '1;
        end
        return (one << size) - one;
    endfunction

    localparam logic [GRAY_MAX_WIDTH-1:0] GRAY_MAX_BIN = gray_max_bin(GRAY_SIZE_DEFAULT);

endpackage

// File: rtl/binary_to_gray_ds.sv
// Combinational binary-to-Gray stage; mirror image of the downstream Gray-to-binary converter.
module binary_to_gray_ds
    import gray_pkg::*;
#(
    parameter int unsigned SIZE = GRAY_SIZE_DEFAULT
) (
    input  logic [SIZE-1:0] bin_i,
    output logic [SIZE-1:0] gray_o
);

    assign gray_o = SIZE'(bin2gray(GRAY_MAX_WIDTH'(bin_i)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray output and a valid/ready output handshake.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int unsigned SIZE = GRAY_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up_dn,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
    input  logic            out_ready,
    output logic [SIZE-1:0] G,
    output logic            out_valid,
    output logic            wrap,
    output logic [SIZE-1:0] bin_q
);

    localparam logic [SIZE-1:0] MaxBin = SIZE'(gray_max_bin(SIZE));

    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] g_d;
    logic [SIZE-1:0] g_q;
    logic            valid_d;
    logic            valid_q;
    logic            wrap_d;
    logic            wrap_q;
    logic            stall;
    logic            step;

    // A held, unconsumed code blocks counting; a load still goes through.
    assign stall = valid_q & ~out_ready;
    assign step  = en & ~load & ~stall;

    always_comb begin
        bin_d   = bin_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (load) begin
            bin_d   = load_bin;
            valid_d = 1'b1;
        end else if (step) begin
            if (up_dn) begin
                bin_d  = bin_q + SIZE'(1);
                wrap_d = (bin_q == MaxBin);
            end else begin
                bin_d  = bin_q - SIZE'(1);
                wrap_d = (bin_q == '0);
            end
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // G always tracks the next count, so it holds whenever bin_q holds.
    binary_to_gray_ds #(
        .SIZE (SIZE)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (g_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            g_q     <= g_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign G         = g_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule
